// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory bus between the fetch (i_)
// and load/store (d_) ports, with registered command issue, stall watchdog and sticky errors.
module mips_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_waitrequest,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_waitrequest,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_waitrequest,
  output logic                busy,
  output logic                timeout_err,
  output logic                protocol_err
);

  localparam int          BE_W    = DATA_W / 8;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RSP_I,
    RSP_D
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant_d;
  logic [15:0] wd_count;
  logic        d_req;
  logic        pick_i;
  logic        pick_d;
  logic        done;
  logic        expired;

  // Round robin: on a tie the port that did not win last time gets the bus.
  assign d_req   = d_read | d_write;
  assign pick_i  = i_read && (!d_req || last_grant_d);
  assign pick_d  = d_req && (!i_read || !last_grant_d);
  assign done    = !mem_waitrequest;
  assign expired = mem_waitrequest && (wd_count == WD_LAST);

  assign busy          = (state != IDLE);
  assign i_waitrequest = (state != RSP_I);
  assign d_waitrequest = (state != RSP_D);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_i) begin
          state_next = GNT_I;
        end else if (pick_d) begin
          state_next = GNT_D;
        end
      end
      GNT_I: begin
        if (done || expired) begin
          state_next = RSP_I;
        end
      end
      GNT_D: begin
        if (done || expired) begin
          state_next = RSP_D;
        end
      end
      RSP_I:   state_next = IDLE;
      RSP_D:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
      i_readdata     <= '0;
      d_readdata     <= '0;
      last_grant_d   <= 1'b1;
      wd_count       <= '0;
      timeout_err    <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_count <= '0;
          if (pick_i) begin
            mem_address    <= i_address;
            mem_read       <= 1'b1;
            mem_write      <= 1'b0;
            mem_byteenable <= {BE_W{1'b1}};
            last_grant_d   <= 1'b0;
          end else if (pick_d) begin
            // Writes win when a broken requester raises both strobes.
            mem_address    <= d_address;
            mem_read       <= !d_write;
            mem_write      <= d_write;
            mem_writedata  <= d_writedata;
            mem_byteenable <= d_byteenable;
            last_grant_d   <= 1'b1;
            if (d_read && d_write) begin
              protocol_err <= 1'b1;
            end
          end
        end
        GNT_I, GNT_D: begin
          if (done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) begin
              if (state == GNT_I) begin
                i_readdata <= mem_readdata;
              end else begin
                d_readdata <= mem_readdata;
              end
            end
          end else if (expired) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            timeout_err <= 1'b1;
            if (state == GNT_I) begin
              i_readdata <= '0;
            end else begin
              d_readdata <= '0;
            end
          end else begin
            wd_count <= wd_count + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed test of mips_bus_arbiter: grants, round robin, stalls, watchdog, errors, async reset.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_readdata;
  logic        i_waitrequest;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_waitrequest;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        busy;
  logic        timeout_err;
  logic        protocol_err;

  int n_checks = 0;
  int n_errors = 0;

  mips_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_read(i_read),
    .i_address(i_address),
    .i_readdata(i_readdata),
    .i_waitrequest(i_waitrequest),
    .d_read(d_read),
    .d_write(d_write),
    .d_address(d_address),
    .d_writedata(d_writedata),
    .d_byteenable(d_byteenable),
    .d_readdata(d_readdata),
    .d_waitrequest(d_waitrequest),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest),
    .busy(busy),
    .timeout_err(timeout_err),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
    mem_readdata = '0; mem_waitrequest = 1'b0;
    repeat (2) tick();

    check_val("rst_mem_read", 32'(mem_read), 32'd0);
    check_val("rst_mem_write", 32'(mem_write), 32'd0);
    check_val("rst_mem_address", mem_address, 32'd0);
    check_val("rst_mem_be", 32'(mem_byteenable), 32'd0);
    check_val("rst_i_wait", 32'(i_waitrequest), 32'd1);
    check_val("rst_d_wait", 32'(d_waitrequest), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_i_readdata", i_readdata, 32'd0);
    check_val("rst_errs", {30'd0, timeout_err, protocol_err}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Tie straight after reset: fetch first, then the write.
    i_read = 1'b1; i_address = 32'hBFC00000;
    d_write = 1'b1; d_address = 32'hBFC00010; d_writedata = 32'h0000FFF0; d_byteenable = 4'b1111;
    mem_readdata = 32'h3C02FFF0; mem_waitrequest = 1'b0;
    tick();
    check_val("tie_gnt_i_read", 32'(mem_read), 32'd1);
    check_val("tie_gnt_i_write", 32'(mem_write), 32'd0);
    check_val("tie_gnt_i_addr", mem_address, 32'hBFC00000);
    check_val("tie_gnt_i_busy", 32'(busy), 32'd1);
    tick();
    check_val("tie_rsp_i_wait", 32'(i_waitrequest), 32'd0);
    check_val("tie_rsp_i_dwait", 32'(d_waitrequest), 32'd1);
    check_val("tie_rsp_i_data", i_readdata, 32'h3C02FFF0);
    i_read = 1'b0;
    tick();
    check_val("tie_idle_busy", 32'(busy), 32'd0);
    tick();
    check_val("tie_gnt_d_write", 32'(mem_write), 32'd1);
    check_val("tie_gnt_d_read", 32'(mem_read), 32'd0);
    check_val("tie_gnt_d_addr", mem_address, 32'hBFC00010);
    check_val("tie_gnt_d_wdata", mem_writedata, 32'h0000FFF0);
    check_val("tie_gnt_d_be", 32'(mem_byteenable), 32'hF);
    d_write = 1'b0;
    tick();
    check_val("tie_rsp_d_wait", 32'(d_waitrequest), 32'd0);
    check_val("tie_rsp_d_iwait", 32'(i_waitrequest), 32'd1);
    check_val("tie_rsp_d_iwait_data", i_readdata, 32'h3C02FFF0);
    tick();
    check_val("tie_protocol_err", 32'(protocol_err), 32'd0);
    $display("txn tie: fetch then write done");

    // Continuous contention: grants alternate starting with I.
    i_read = 1'b1; i_address = 32'h00001000;
    d_read = 1'b1; d_address = 32'h00002000; d_byteenable = 4'b1111;
    mem_readdata = 32'h11111111;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val($sformatf("rr%0d_addr", k), mem_address, (k % 2 == 0) ? 32'h00001000 : 32'h00002000);
      tick();
      check_val($sformatf("rr%0d_i_wait", k), 32'(i_waitrequest), (k % 2 == 0) ? 32'd0 : 32'd1);
      check_val($sformatf("rr%0d_d_wait", k), 32'(d_waitrequest), (k % 2 == 0) ? 32'd1 : 32'd0);
      tick();
      $display("txn rr%0d: granted %s", k, (k % 2 == 0) ? "I" : "D");
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();

    // Fetch with zero stall.
    i_read = 1'b1; i_address = 32'hBFC00000;
    mem_readdata = 32'h3C02FFF0; mem_waitrequest = 1'b0;
    tick();
    check_val("fetch_gnt_read", 32'(mem_read), 32'd1);
    check_val("fetch_gnt_addr", mem_address, 32'hBFC00000);
    check_val("fetch_gnt_be", 32'(mem_byteenable), 32'hF);
    check_val("fetch_gnt_iwait", 32'(i_waitrequest), 32'd1);
    i_read = 1'b0;
    tick();
    check_val("fetch_rsp_read", 32'(mem_read), 32'd0);
    check_val("fetch_rsp_iwait", 32'(i_waitrequest), 32'd0);
    check_val("fetch_rsp_data", i_readdata, 32'h3C02FFF0);
    check_val("fetch_rsp_dwait", 32'(d_waitrequest), 32'd1);
    tick();
    check_val("fetch_idle_iwait", 32'(i_waitrequest), 32'd1);
    check_val("fetch_idle_busy", 32'(busy), 32'd0);
    $display("txn fetch: addr bfc00000 data %h", i_readdata);

    // Data read stalled for 5 cycles, completing in the 6th grant cycle.
    d_read = 1'b1; d_address = 32'h00000100; d_byteenable = 4'b0011;
    mem_waitrequest = 1'b1;
    tick();
    d_read = 1'b0; d_address = 32'hFFFFFFFF; d_byteenable = 4'b1100;
    for (int c = 1; c <= 6; c++) begin
      check_val($sformatf("stall%0d_addr", c), mem_address, 32'h00000100);
      check_val($sformatf("stall%0d_read", c), 32'(mem_read), 32'd1);
      check_val($sformatf("stall%0d_be", c), 32'(mem_byteenable), 32'h3);
      check_val($sformatf("stall%0d_dwait", c), 32'(d_waitrequest), 32'd1);
      mem_readdata = 32'hA0000000 + 32'(c);
      if (c == 6) mem_waitrequest = 1'b0;
      tick();
    end
    check_val("stall_rsp_dwait", 32'(d_waitrequest), 32'd0);
    check_val("stall_rsp_data", d_readdata, 32'hA0000006);
    check_val("stall_rsp_read", 32'(mem_read), 32'd0);
    tick();
    $display("txn stall read: data %h", d_readdata);

    // Watchdog abort after 16 stalled cycles.
    d_read = 1'b1; d_address = 32'h00000200; d_byteenable = 4'b1111;
    mem_waitrequest = 1'b1; mem_readdata = 32'hDEADBEEF;
    tick();
    d_read = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check_val($sformatf("wd%0d_read", c), 32'(mem_read), 32'd1);
      check_val($sformatf("wd%0d_terr", c), 32'(timeout_err), 32'd0);
      tick();
    end
    check_val("wd_rsp_read", 32'(mem_read), 32'd0);
    check_val("wd_rsp_dwait", 32'(d_waitrequest), 32'd0);
    check_val("wd_rsp_data", d_readdata, 32'd0);
    check_val("wd_rsp_terr", 32'(timeout_err), 32'd1);
    tick();
    check_val("wd_idle_terr", 32'(timeout_err), 32'd1);
    check_val("wd_idle_busy", 32'(busy), 32'd0);
    mem_waitrequest = 1'b0; mem_readdata = 32'h12345678;
    d_read = 1'b1; d_address = 32'h00000300;
    tick();
    check_val("wd_next_addr", mem_address, 32'h00000300);
    d_read = 1'b0;
    tick();
    check_val("wd_next_dwait", 32'(d_waitrequest), 32'd0);
    check_val("wd_next_data", d_readdata, 32'h12345678);
    check_val("wd_next_terr", 32'(timeout_err), 32'd1);
    tick();
    $display("txn timeout: aborted, next read data %h", d_readdata);

    // Read and write together: write issued, protocol_err raised.
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h00000400; d_writedata = 32'h55AA55AA;
    d_byteenable = 4'b0101;
    tick();
    check_val("perr_write", 32'(mem_write), 32'd1);
    check_val("perr_read", 32'(mem_read), 32'd0);
    check_val("perr_wdata", mem_writedata, 32'h55AA55AA);
    check_val("perr_flag", 32'(protocol_err), 32'd1);
    d_read = 1'b0; d_write = 1'b0;
    tick();
    check_val("perr_rsp_data", d_readdata, 32'h12345678);
    tick();
    check_val("perr_sticky", 32'(protocol_err), 32'd1);
    $display("txn protocol error: write issued");

    // Asynchronous reset in the middle of a stalled fetch.
    i_read = 1'b1; i_address = 32'hBFC00020; mem_waitrequest = 1'b1;
    tick();
    check_val("mid_gnt_read", 32'(mem_read), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_val("mid_rst_read", 32'(mem_read), 32'd0);
    check_val("mid_rst_iwait", 32'(i_waitrequest), 32'd1);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_errs", {30'd0, timeout_err, protocol_err}, 32'd0);
    tick();
    reset_n = 1'b1; mem_waitrequest = 1'b0; mem_readdata = 32'h8C220004;
    tick();
    check_val("mid_re_read", 32'(mem_read), 32'd1);
    check_val("mid_re_addr", mem_address, 32'hBFC00020);
    i_read = 1'b0;
    tick();
    check_val("mid_re_iwait", 32'(i_waitrequest), 32'd0);
    check_val("mid_re_data", i_readdata, 32'h8C220004);
    tick();
    $display("txn reset mid-grant: fetch reissued data %h", i_readdata);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-requester arbiter that shares the single CPU memory bus (Avalon-style: address/read/write/writedata/byteenable/readdata/waitrequest) between the instruction-fetch port (i_) and the load/store port (d_) of mips_cpu_bus.
- Round-robin grant, one outstanding transfer at a time, with registered command issue, waitrequest stall handling, a bus timeout watchdog and sticky error flags.
- Sits between the CPU core datapath and the external memory interface driven by the testbenches.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byteenable width is DATA_W/8
- TIMEOUT_CYCLES, 256, maximum stall cycles in a grant state before abort; legal range 1..65535

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_read  in  1  fetch read request
- i_address  in  ADDR_W  fetch address
- i_readdata  out  DATA_W  fetch read data, valid when i_waitrequest=0
- i_waitrequest  out  1  low for exactly one cycle on fetch completion
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_address  in  ADDR_W  data address
- d_writedata  in  DATA_W  store data
- d_byteenable  in  DATA_W/8  store/load byte lanes
- d_readdata  out  DATA_W  load data, valid when d_waitrequest=0
- d_waitrequest  out  1  low for exactly one cycle on data completion
- mem_address  out  ADDR_W  bus address
- mem_read  out  1  bus read strobe
- mem_write  out  1  bus write strobe
- mem_writedata  out  DATA_W  bus write data
- mem_byteenable  out  DATA_W/8  bus byte lanes
- mem_readdata  in  DATA_W  bus read data, valid in completion cycle
- mem_waitrequest  in  1  bus stall
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky: a transfer was aborted by the watchdog
- protocol_err  out  1  sticky: d_read and d_write were both high when sampled

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_read=mem_write=0; mem_address, mem_writedata, i_readdata, d_readdata = 0; mem_byteenable=0; i_waitrequest=d_waitrequest=1; busy=0; both error flags=0; last_grant=D, so I wins the first tie. Outputs take reset values immediately, not at the next edge.
- FSM states: IDLE, GNT_I, GNT_D, RSP_I, RSP_D.
- IDLE: sample requests. Only I requesting -> GNT_I. Only D requesting -> GNT_D. Both requesting -> grant the port not equal to last_grant. On the grant edge, latch the granted port's command into the mem_* registers and set last_grant.
- Fetch command: mem_read=1, mem_byteenable=all ones.
- Data command: d_write has priority. If d_read and d_write are both high, issue a write and set protocol_err.
- GNT_x: command held stable on mem_* while mem_waitrequest=1. The watchdog counter resets on entry and increments each stalled cycle.
- Completion cycle: the GNT_x cycle in which mem_waitrequest=0. On that edge, capture mem_readdata into x_readdata (writes leave x_readdata unchanged), clear mem_read/mem_write, and go to RSP_x.
- Watchdog: counter reaches TIMEOUT_CYCLES with mem_waitrequest still 1 -> clear the strobes, set x_readdata=0, set timeout_err, go to RSP_x.
- RSP_x: x_waitrequest=0 for exactly this one cycle, then IDLE. The requester must drop or change its request after observing waitrequest=0; a request still high in IDLE is a new transfer.
- Port waitrequest is 1 in every state except that port's RSP cycle, whether or not the port is requesting.
- Latency, zero-stall transfer:
  - edge 1: IDLE -> GNT, command issued
  - edge 2: completion -> RSP
  - the RSP cycle shows waitrequest=0
  - minimum 3 cycles per transfer, request to requester completion.
- Requester inputs are ignored outside IDLE; changes during GNT/RSP do not alter the bus.
- busy=1 in GNT_x and RSP_x.
- Error flags clear only on reset.

Test Plan:
- Fetch, zero stall: i_read=1, i_address=0xBFC00000, mem_readdata=0x3C02FFF0, mem_waitrequest=0 -> mem_read high exactly 1 cycle with mem_address=0xBFC00000; i_waitrequest=0 on the 3rd cycle with i_readdata=0x3C02FFF0; d_waitrequest stays 1.
- Tie after reset: i_read and d_write (d_address=0xBFC00010, d_writedata=0x0000FFF0, d_byteenable=4'b1111) asserted together -> fetch issued first; then write issued with exactly those values; each port sees one waitrequest=0 pulse.
- Continuous contention: both ports re-request immediately after every completion for 8 transfers -> grant order I,D,I,D,I,D,I,D.
- Stall: mem_waitrequest=1 for 5 cycles on a d_read -> mem_address, mem_read and mem_byteenable stable for all 6 grant cycles; d_readdata matches the mem_readdata value present in the 6th cycle.
- Timeout: TIMEOUT_CYCLES=16, mem_waitrequest held 1 -> strobes drop after 16 stalled cycles; d_waitrequest pulses 0 with d_readdata=0; timeout_err=1 and stays 1; the next transfer completes normally.
- Reset mid-grant: reset_n pulled low during GNT_I with a stall -> mem_read=0, i_waitrequest=1 and busy=0 immediately, without waiting for clk; after release with i_read still high, the fetch is reissued and completes.
